// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM state codes and ALU operation encodings for the multi-cycle CPU.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned NREGS   = 16;
    localparam int unsigned REG_AW  = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // ALU operation used by an opcode; address and immediate forms all add.
    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Opcodes 0xB..0xE are unassigned and trap.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/multicycle_cpu_if.sv
// Unified instruction/data memory port with req/ready handshake.
interface multicycle_cpu_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/cpu_regfile.sv
// 16-entry register file: two combinational reads, one synchronous write, r0 reads zero.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_a_c,
    output logic [DATA_W-1:0] rdata_b_c
);

    logic [DATA_W-1:0] regs [NREGS];

    // Clear on reset; writes to r0 are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a_c = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b_c = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: FETCH/DECODE/EXEC/MEM/WB over one handshaked memory port.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_cpu_if.master  bus,
    output logic [ADDR_W-1:0] pc_o,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic               req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               retire_q, retire_d, halted_q, halted_d, illegal_q, illegal_d;

    logic [3:0]         op_c;
    logic [DATA_W-1:0]  imm_c, opb_c, alu_c, rf_a_c, rf_b_c, rf_wd_c;
    logic [ADDR_W-1:0]  br_off_c, jmp_off_c;
    logic [REG_AW-1:0]  rf_wa_c;
    logic               rf_we_c, is_rtype_c;

    assign op_c       = ir_q[15:12];
    assign is_rtype_c = (op_c <= OP_SLT);
    assign imm_c      = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
    assign br_off_c   = {{(ADDR_W-4){ir_q[3]}}, ir_q[3:0]};
    assign jmp_off_c  = {{(ADDR_W-12){ir_q[11]}}, ir_q[11:0]};
    assign opb_c      = is_rtype_c ? b_q : imm_c;

    assign rf_we_c = (state_q == S_WB);
    assign rf_wa_c = is_rtype_c ? ir_q[3:0] : ir_q[7:4];
    assign rf_wd_c = (op_c == OP_LW) ? mdr_q : alu_q;

    cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a   (ir_q[11:8]),
        .raddr_b   (ir_q[7:4]),
        .we        (rf_we_c),
        .waddr     (rf_wa_c),
        .wdata     (rf_wd_c),
        .rdata_a_c (rf_a_c),
        .rdata_b_c (rf_b_c)
    );

    // ALU on latched operands; SLT compares as signed.
    always_comb begin
        alu_c = '0;
        case (alu_op_of(op_c))
            ALU_ADD: alu_c = a_q + opb_c;
            ALU_SUB: alu_c = a_q - opb_c;
            ALU_AND: alu_c = a_q & opb_c;
            ALU_OR:  alu_c = a_q | opb_c;
            ALU_SLT: alu_c = ($signed(a_q) < $signed(opb_c)) ? DATA_W'(1) : '0;
            default: alu_c = '0;
        endcase
    end

    // Next-state logic; bus outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        req_d     = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        retire_d  = 1'b0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (req_q && bus.ready) begin
                    ir_d    = bus.rdata[15:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end else begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end
            S_DECODE: begin
                a_d = rf_a_c;
                b_d = rf_b_c;
                if (op_c == OP_HALT || is_illegal(op_c)) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    illegal_d = is_illegal(op_c);
                    retire_d  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_c;
                case (op_c)
                    OP_BEQ, OP_BNE, OP_JMP: begin
                        if (op_c == OP_JMP)
                            pc_d = pc_q + jmp_off_c;
                        else if ((a_q == b_q) == (op_c == OP_BEQ))
                            pc_d = pc_q + br_off_c;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                        req_d    = 1'b1;
                        addr_d   = pc_d;
                    end
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                        req_d   = 1'b1;
                        we_d    = (op_c == OP_SW);
                        addr_d  = ADDR_W'(alu_c);
                        wdata_d = b_q;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (req_q && bus.ready) begin
                    if (op_c == OP_SW) begin
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                        req_d    = 1'b1;
                        addr_d   = pc_q;
                    end else begin
                        mdr_d   = bus.rdata;
                        state_d = S_WB;
                    end
                end else begin
                    req_d = 1'b1;
                    we_d  = we_q;
                end
            end
            S_WB: begin
                retire_d = 1'b1;
                state_d  = S_FETCH;
                req_d    = 1'b1;
                addr_d   = pc_q;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            retire_q  <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            retire_q  <= retire_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign pc_o      = pc_q;
    assign retire    = retire_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench: wait-state memory model, event monitor, scoreboard queues.
module tb_multicycle_cpu;
    import cpu_pkg::*;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_cpu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    logic [ADDR_W-1:0] pc_o;
    logic retire, halted, illegal;

    multicycle_cpu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .pc_o(pc_o), .retire(retire), .halted(halted), .illegal(illegal)
    );

    // Memory model: image copied in during reset, fixed wait states per access.
    logic [15:0] img [256];
    logic [15:0] mem_arr [256];
    int unsigned wait_cfg = 0;
    int unsigned wcnt;

    assign bus.ready = bus.req && (wcnt >= wait_cfg);
    assign bus.rdata = mem_arr[bus.addr[7:0]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= img[i];
            wcnt <= 0;
        end else begin
            if (bus.req && bus.ready && bus.we) mem_arr[bus.addr[7:0]] <= bus.wdata;
            if (!bus.req || bus.ready) wcnt <= 0;
            else wcnt <= wcnt + 1;
        end
    end

    // Monitor: completed accesses and retire pulses, sampled mid-cycle.
    longint      cyc = 0;
    logic [31:0] obs_wr[$];
    logic [15:0] obs_fetch[$];
    longint      obs_ret[$];
    int unsigned req_while_halted = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.req && bus.ready) begin
                if (bus.we) obs_wr.push_back({bus.addr, bus.wdata});
                else        obs_fetch.push_back(bus.addr);
            end
            if (retire) obs_ret.push_back(cyc);
            if (halted && bus.req) req_while_halted <= req_while_halted + 1;
        end
    end

    logic [31:0] exp_wr[$];
    logic [15:0] exp_fetch[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 16'h0000;
        exp_wr.delete();
        exp_fetch.delete();
    endtask

    task automatic apply_reset(input int unsigned waits);
        @(negedge clk);
        rst_n = 1'b0;
        wait_cfg = waits;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs_wr.delete();
        obs_fetch.delete();
        obs_ret.delete();
        req_while_halted = 0;
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    // ALU program: r1=5, r2=-3, then ADD/SUB/AND/OR stored at 16..19 via base r7=12.
    task automatic load_alu_prog();
        clear_img();
        img[0]  = ins(OP_ADDI, 0, 1, 5);
        img[1]  = ins(OP_ADDI, 0, 2, 4'hD);
        img[2]  = ins(OP_ADD,  1, 2, 3);
        img[3]  = ins(OP_SUB,  1, 2, 4);
        img[4]  = ins(OP_AND,  1, 2, 5);
        img[5]  = ins(OP_OR,   1, 2, 6);
        img[6]  = ins(OP_ADDI, 1, 7, 7);
        img[7]  = ins(OP_SW,   7, 3, 4);
        img[8]  = ins(OP_SW,   7, 4, 5);
        img[9]  = ins(OP_SW,   7, 5, 6);
        img[10] = ins(OP_SW,   7, 6, 7);
        img[11] = 16'hF000;
        exp_wr.push_back({16'd16, 16'd2});
        exp_wr.push_back({16'd17, 16'd8});
        exp_wr.push_back({16'd18, 16'h0005});
        exp_wr.push_back({16'd19, 16'hFFFD});
    endtask

    task automatic test_reset();
        bit found;
        bit to;
        load_alu_prog();
        apply_reset(1);
        repeat (12) @(negedge clk);
        checks++;
        if (pc_o === 16'd0) begin
            failures++;
            $display("FAIL reset_pre_pc: pc_o=%0d, required nonzero before reset", pc_o);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req && !bus.ready && !bus.we) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL reset_midfetch: no stalled fetch seen within bound");
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", bus.req); end
        checks++;
        if (pc_o !== 16'd0) begin failures++; $display("FAIL reset_pc: got %0d want 0", pc_o); end
        checks++;
        if ({halted, illegal, retire} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: halted/illegal/retire=%b want 000", {halted, illegal, retire});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req !== 1'b0) begin failures++; $display("FAIL reset_req_hold: got %b want 0", bus.req); end
        rst_n = 1'b1;
        run_until_halt(600, to);
        checks++;
        if (to !== 1'b0) begin failures++; $display("FAIL reset_recover: no halt after reset release"); end
        checks++;
        if (obs_wr.size() < 1 || obs_wr[0] !== exp_wr[0]) begin
            failures++;
            $display("FAIL reset_recover_wr: first write missing or wrong, want %h", exp_wr[0]);
        end
    endtask

    task automatic test_alu();
        bit to;
        logic [31:0] e, o;
        load_alu_prog();
        apply_reset(0);
        run_until_halt(300, to);
        checks++;
        if (to !== 1'b0) begin failures++; $display("FAIL alu_timeout: halted not reached"); end
        checks++;
        if (obs_wr.size() !== exp_wr.size()) begin
            failures++;
            $display("FAIL alu_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL alu_wr: got addr/data %h want %h", o, e); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_ret.size() < 4 || (obs_ret[i+1] - obs_ret[i]) != 4) begin
                failures++;
                $display("FAIL alu_retire_gap%0d: retire spacing wrong, want 4", i);
            end
        end
        checks++;
        if ({halted, illegal} !== 2'b10) begin
            failures++;
            $display("FAIL alu_halt: halted/illegal=%b want 10", {halted, illegal});
        end
    endtask

    task automatic test_mem_wait();
        bit to;
        logic [31:0] e, o;
        clear_img();
        img[0]  = ins(OP_ADDI, 0, 1, 5);
        img[1]  = ins(OP_ADDI, 0, 2, 4'hD);
        img[2]  = ins(OP_ADD,  1, 2, 3);
        img[3]  = 16'hA004;
        img[8]  = ins(OP_SW,   0, 3, 4);
        img[9]  = ins(OP_LW,   0, 4, 4);
        img[10] = ins(OP_SW,   0, 4, 6);
        img[11] = 16'hF000;
        exp_wr.push_back({16'd4, 16'd2});
        exp_wr.push_back({16'd6, 16'd2});
        apply_reset(2);
        run_until_halt(600, to);
        checks++;
        if (to !== 1'b0) begin failures++; $display("FAIL mem_timeout: halted not reached"); end
        checks++;
        if (obs_wr.size() !== exp_wr.size()) begin
            failures++;
            $display("FAIL mem_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL mem_wr: got addr/data %h want %h", o, e); end
        end
        // Latency = base + wait states on the fetch (2) and, for memory ops, the data access (2).
        checks++;
        if (obs_ret.size() < 6 || (obs_ret[3] - obs_ret[2]) != 5) begin
            failures++; $display("FAIL mem_jmp_latency: want 5 cycles");
        end
        checks++;
        if (obs_ret.size() < 6 || (obs_ret[4] - obs_ret[3]) != 8) begin
            failures++; $display("FAIL mem_sw_latency: want 8 cycles");
        end
        checks++;
        if (obs_ret.size() < 6 || (obs_ret[5] - obs_ret[4]) != 9) begin
            failures++; $display("FAIL mem_lw_latency: want 9 cycles");
        end
    endtask

    task automatic test_branch();
        bit to;
        logic [15:0] e, o;
        clear_img();
        img[0]  = ins(OP_ADDI, 0, 1, 5);
        img[1]  = 16'hA008;
        img[10] = ins(OP_BEQ, 1, 1, 4'hF);
        exp_fetch = '{16'd0, 16'd1, 16'd10, 16'd10, 16'd10};
        apply_reset(0);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            e = exp_fetch[i];
            o = (i < obs_fetch.size()) ? obs_fetch[i] : 16'hXXXX;
            checks++;
            if (o !== e) begin failures++; $display("FAIL beq_fetch%0d: got %h want %h", i, o, e); end
        end
        clear_img();
        img[0]  = ins(OP_ADDI, 0, 1, 5);
        img[1]  = ins(OP_ADDI, 0, 2, 4'hD);
        img[2]  = ins(OP_BNE, 1, 2, 5);
        img[8]  = ins(OP_BEQ, 1, 2, 3);
        img[9]  = 16'hA000;
        img[10] = ins(OP_BNE, 1, 1, 3);
        img[11] = 16'hF000;
        exp_fetch = '{16'd0, 16'd1, 16'd2, 16'd8, 16'd9, 16'd10, 16'd11};
        apply_reset(0);
        run_until_halt(200, to);
        checks++;
        if (to !== 1'b0) begin failures++; $display("FAIL br_timeout: halted not reached"); end
        checks++;
        if (obs_fetch.size() !== exp_fetch.size()) begin
            failures++;
            $display("FAIL br_fetch_count: got %0d want %0d", obs_fetch.size(), exp_fetch.size());
        end
        while (exp_fetch.size() > 0 && obs_fetch.size() > 0) begin
            e = exp_fetch.pop_front();
            o = obs_fetch.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL br_fetch: got %h want %h", o, e); end
        end
    endtask

    task automatic test_r0_slt();
        bit to;
        logic [31:0] e, o;
        clear_img();
        img[0]  = ins(OP_ADDI, 0, 0, 7);
        img[1]  = ins(OP_ADD,  0, 0, 5);
        img[2]  = ins(OP_ADDI, 0, 1, 5);
        img[3]  = ins(OP_ADDI, 0, 2, 4'hD);
        img[4]  = ins(OP_SLT,  2, 1, 6);
        img[5]  = ins(OP_SLT,  1, 2, 8);
        img[6]  = ins(OP_ADDI, 1, 7, 7);
        img[7]  = ins(OP_SW,   7, 5, 4);
        img[8]  = ins(OP_SW,   7, 6, 5);
        img[9]  = ins(OP_SW,   7, 8, 6);
        img[10] = 16'hF000;
        exp_wr.push_back({16'd16, 16'd0});
        exp_wr.push_back({16'd17, 16'd1});
        exp_wr.push_back({16'd18, 16'd0});
        apply_reset(0);
        run_until_halt(300, to);
        checks++;
        if (to !== 1'b0) begin failures++; $display("FAIL r0_timeout: halted not reached"); end
        checks++;
        if (obs_wr.size() !== exp_wr.size()) begin
            failures++;
            $display("FAIL r0_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL r0_slt_wr: got addr/data %h want %h", o, e); end
        end
    endtask

    task automatic test_illegal();
        bit to;
        clear_img();
        img[0] = ins(OP_ADDI, 0, 1, 5);
        img[1] = ins(OP_ADDI, 0, 2, 4'hD);
        img[2] = 16'hC000;
        img[3] = ins(OP_ADDI, 0, 1, 5);
        apply_reset(0);
        run_until_halt(200, to);
        repeat (20) @(negedge clk);
        checks++;
        if (to !== 1'b0) begin failures++; $display("FAIL ill_timeout: halted not reached"); end
        checks++;
        if ({halted, illegal} !== 2'b11) begin
            failures++;
            $display("FAIL ill_flags: halted/illegal=%b want 11", {halted, illegal});
        end
        checks++;
        if (obs_fetch.size() == 0 || obs_fetch[obs_fetch.size()-1] !== 16'd2) begin
            failures++;
            $display("FAIL ill_last_fetch: last fetch not address 2");
        end
        checks++;
        if (pc_o !== 16'd3) begin failures++; $display("FAIL ill_pc: got %0d want 3", pc_o); end
        checks++;
        if (req_while_halted !== 0) begin
            failures++;
            $display("FAIL ill_no_req: %0d request cycles while halted, want 0", req_while_halted);
        end
        clear_img();
        img[0] = ins(OP_ADDI, 0, 1, 5);
        img[1] = 16'hF000;
        apply_reset(0);
        run_until_halt(100, to);
        checks++;
        if ({to, halted, illegal} !== 3'b010) begin
            failures++;
            $display("FAIL halt_flags: timeout/halted/illegal=%b want 010", {to, halted, illegal});
        end
        checks++;
        if (obs_ret.size() !== 2) begin
            failures++;
            $display("FAIL halt_retires: got %0d want 2", obs_ret.size());
        end
        checks++;
        if (pc_o !== 16'd2) begin failures++; $display("FAIL halt_pc: got %0d want 2", pc_o); end
    endtask

    initial begin
        clear_img();
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_r0_slt();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
